// File: rtl/axil_master.sv
// AXI4-lite initiator with a single transaction in flight: one command becomes one
// AW/W/B or AR/R exchange, and the result is returned on a valid/ready response port.
module axil_master #(
  parameter int WIDTH_P = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [WIDTH_P-1:0]   cmd_addr,
  input  logic [WIDTH_P-1:0]   cmd_wdata,
  input  logic [WIDTH_P/8-1:0] cmd_wstrb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH_P-1:0]   rsp_rdata,
  output logic [1:0]           rsp_resp,
  output logic [WIDTH_P-1:0]   M_AWADDR,
  output logic                 M_AWVALID,
  input  logic                 M_AWREADY,
  output logic [WIDTH_P-1:0]   M_WDATA,
  output logic [WIDTH_P/8-1:0] M_WSTRB,
  output logic                 M_WVALID,
  input  logic                 M_WREADY,
  input  logic [1:0]           M_BRESP,
  input  logic                 M_BVALID,
  output logic                 M_BREADY,
  output logic [WIDTH_P-1:0]   M_ARADDR,
  output logic                 M_ARVALID,
  input  logic                 M_ARREADY,
  input  logic [WIDTH_P-1:0]   M_RDATA,
  input  logic [1:0]           M_RRESP,
  input  logic                 M_RVALID,
  output logic                 M_RREADY
);
  localparam int STRB_W = WIDTH_P / 8;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP
  } state_e;

  state_e              state_q, state_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [WIDTH_P-1:0]  awaddr_q, awaddr_d;
  logic [WIDTH_P-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [WIDTH_P-1:0]  araddr_q, araddr_d;
  logic [WIDTH_P-1:0]  rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic                aw_hs, w_hs;

  // All VALID/READY outputs decode registered state only, never the slave's READY.
  assign cmd_ready = (state_q == IDLE);
  assign M_AWVALID = (state_q == WR_ADDR_DATA) && !aw_done_q;
  assign M_WVALID  = (state_q == WR_ADDR_DATA) && !w_done_q;
  assign M_BREADY  = (state_q == WR_RESP);
  assign M_ARVALID = (state_q == RD_ADDR);
  assign M_RREADY  = (state_q == RD_DATA);
  assign rsp_valid = (state_q == RSP);

  assign M_AWADDR  = awaddr_q;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = wstrb_q;
  assign M_ARADDR  = araddr_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  assign aw_hs = M_AWVALID && M_AWREADY;
  assign w_hs  = M_WVALID && M_WREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      araddr_q  <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_we) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_ADDR_DATA;
          end else begin
            araddr_d = cmd_addr;
            state_d  = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        // AW and W complete independently; both may land in the same cycle.
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (M_BVALID) begin
          resp_d  = M_BRESP;
          rdata_d = '0;
          state_d = RSP;
        end
      end
      RD_ADDR: begin
        if (M_ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (M_RVALID) begin
          rdata_d = M_RDATA;
          resp_d  = M_RRESP;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: a memory-backed AXI4-lite slave with programmable stalls,
// a table of directed transactions, hand-written corner sequences and random traffic.
module tb_axil_master;
  localparam int W  = 32;
  localparam int SW = W / 8;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [W-1:0]  cmd_addr, cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [W-1:0]  M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
  logic [SW-1:0] M_WSTRB;
  logic          M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
  logic [1:0]    M_BRESP, M_RRESP;
  logic          M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

  axil_master #(.WIDTH_P(W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic          we;
    logic [W-1:0]  addr;
    logic [W-1:0]  wdata;
    logic [SW-1:0] wstrb;
    int            aw_dly, w_dly, ar_dly, b_dly, r_dly;
    logic [1:0]    resp;
    int            hold;
    logic [W-1:0]  exp_rdata;
    logic [1:0]    exp_resp;
  } vec_t;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int stab_err = 0;

  // Slave configuration (set per transaction) and observations.
  int         cfg_aw_dly, cfg_w_dly, cfg_ar_dly, cfg_b_dly, cfg_r_dly;
  logic [1:0] cfg_resp;
  int         n_aw, n_w, n_b, n_ar, n_r, rready_gap;
  int         aw_cyc, w_cyc, hs_cyc;
  logic [W-1:0]  seen_awaddr, seen_araddr, seen_wdata;
  logic [SW-1:0] seen_wstrb;
  logic [W-1:0]  smem [logic [W-1:0]];
  logic [W-1:0]  model_mem [logic [W-1:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                         input logic [SW-1:0] s);
    logic [W-1:0] r;
    r = old;
    for (int i = 0; i < SW; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic vec_t mk(input logic we, input logic [W-1:0] a, input logic [W-1:0] d,
                              input logic [SW-1:0] s, input int awd, input int wd, input int ard,
                              input int bd, input int rd, input logic [1:0] resp, input int hold,
                              input logic [W-1:0] erd, input logic [1:0] ers);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.wstrb = s;
    v.aw_dly = awd; v.w_dly = wd; v.ar_dly = ard; v.b_dly = bd; v.r_dly = rd;
    v.resp = resp; v.hold = hold; v.exp_rdata = erd; v.exp_resp = ers;
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge ACLK);
      cyc++;
    end
  end

  // Memory slave: handshakes are decided on the falling edge, reactions applied after the rise.
  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit aw_got, w_got, b_pend, r_pend;
    int aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
    logic [W-1:0] r_addr, old;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0; r_addr = '0;
    M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = 0;
    M_ARREADY = 0; M_RVALID = 0; M_RDATA = 0; M_RRESP = 0;
    forever begin
      @(negedge ACLK);
      aw_hs = !ARESET && M_AWVALID && M_AWREADY;
      w_hs  = !ARESET && M_WVALID && M_WREADY;
      b_hs  = !ARESET && M_BVALID && M_BREADY;
      ar_hs = !ARESET && M_ARVALID && M_ARREADY;
      r_hs  = !ARESET && M_RVALID && M_RREADY;
      if (aw_hs) begin n_aw++; aw_cyc = cyc + 1; seen_awaddr = M_AWADDR; end
      if (w_hs)  begin n_w++; w_cyc = cyc + 1; seen_wdata = M_WDATA; seen_wstrb = M_WSTRB; end
      if (ar_hs) begin n_ar++; seen_araddr = M_ARADDR; end
      if (b_hs)  begin n_b++; hs_cyc = cyc + 1; end
      if (r_hs)  begin n_r++; hs_cyc = cyc + 1; end
      if (!ARESET && r_pend && !M_RVALID && !M_RREADY) rready_gap++;
      @(posedge ACLK);
      #1;
      if (ARESET) begin
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_ARREADY = 0; M_RVALID = 0;
      end else begin
        if (aw_hs) begin aw_got = 1; aw_cnt = 0; end
        if (w_hs)  begin w_got = 1; w_cnt = 0; end
        if (ar_hs) begin ar_cnt = 0; r_pend = 1; r_wait = 0; r_addr = seen_araddr; end
        if (b_hs)  begin M_BVALID = 0; b_pend = 0; end
        if (r_hs)  begin M_RVALID = 0; r_pend = 0; end
        if (aw_got && w_got) begin
          old = smem.exists(seen_awaddr) ? smem[seen_awaddr] : '0;
          smem[seen_awaddr] = merge(old, seen_wdata, seen_wstrb);
          aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
        end
        if (b_pend && !M_BVALID) begin
          if (b_wait >= cfg_b_dly) begin M_BVALID = 1; M_BRESP = cfg_resp; end
          else b_wait++;
        end
        if (r_pend && !M_RVALID) begin
          if (r_wait >= cfg_r_dly) begin
            M_RVALID = 1;
            M_RDATA  = smem.exists(r_addr) ? smem[r_addr] : '0;
            M_RRESP  = cfg_resp;
          end else r_wait++;
        end
        M_AWREADY = M_AWVALID && (aw_cnt >= cfg_aw_dly);
        if (M_AWVALID) aw_cnt++;
        M_WREADY = M_WVALID && (w_cnt >= cfg_w_dly);
        if (M_WVALID) w_cnt++;
        M_ARREADY = M_ARVALID && (ar_cnt >= cfg_ar_dly);
        if (M_ARVALID) ar_cnt++;
      end
    end
  end

  // A VALID that was not accepted must stay high with unchanged payload.
  logic          pv_aw, ph_aw, pv_w, ph_w, pv_ar, ph_ar, pv_rs, ph_rs;
  logic [W-1:0]  p_awaddr, p_wdata, p_araddr, p_rdata;
  logic [SW-1:0] p_wstrb;
  logic [1:0]    p_resp;
  initial begin
    pv_aw = 0; ph_aw = 0; pv_w = 0; ph_w = 0; pv_ar = 0; ph_ar = 0; pv_rs = 0; ph_rs = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESET) begin
        if (pv_aw && !ph_aw && (!M_AWVALID || M_AWADDR !== p_awaddr)) stab_err++;
        if (pv_w && !ph_w && (!M_WVALID || M_WDATA !== p_wdata || M_WSTRB !== p_wstrb)) stab_err++;
        if (pv_ar && !ph_ar && (!M_ARVALID || M_ARADDR !== p_araddr)) stab_err++;
        if (pv_rs && !ph_rs && (!rsp_valid || rsp_rdata !== p_rdata || rsp_resp !== p_resp)) stab_err++;
      end
      pv_aw = M_AWVALID; ph_aw = M_AWVALID && M_AWREADY; p_awaddr = M_AWADDR;
      pv_w  = M_WVALID;  ph_w  = M_WVALID && M_WREADY;  p_wdata = M_WDATA; p_wstrb = M_WSTRB;
      pv_ar = M_ARVALID; ph_ar = M_ARVALID && M_ARREADY; p_araddr = M_ARADDR;
      pv_rs = rsp_valid; ph_rs = rsp_valid && rsp_ready; p_rdata = rsp_rdata; p_resp = rsp_resp;
    end
  end

  task automatic clear_stats();
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; rready_gap = 0;
    aw_cyc = 0; w_cyc = 0; hs_cyc = -1;
  endtask

  task automatic send_cmd(input logic we, input logic [W-1:0] a, input logic [W-1:0] d,
                          input logic [SW-1:0] s);
    bit acc;
    acc = 0;
    cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge ACLK);
      acc = cmd_ready;
      @(posedge ACLK);
      #1;
    end
    cmd_valid = 0;
    chk("cmd_accept", 64'(acc), 1);
  endtask

  task automatic wait_rsp(output int rc);
    for (int i = 0; i < 200 && !rsp_valid; i++) begin
      @(posedge ACLK);
      #1;
    end
    chk("rsp_wait", 64'(rsp_valid), 1);
    rc = cyc;
  endtask

  task automatic take_rsp(input int hold, output logic [W-1:0] rd, output logic [1:0] rs);
    rd = rsp_rdata;
    rs = rsp_resp;
    repeat (hold) begin
      @(posedge ACLK);
      #1;
    end
    rsp_ready = 1;
    @(posedge ACLK);
    #1;
    rsp_ready = 0;
  endtask

  task automatic model_write(input logic [W-1:0] a, input logic [W-1:0] d, input logic [SW-1:0] s);
    logic [W-1:0] old;
    old = model_mem.exists(a) ? model_mem[a] : '0;
    model_mem[a] = merge(old, d, s);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [W-1:0] rd;
    logic [1:0]   rs;
    int           rc;
    cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_ar_dly = v.ar_dly;
    cfg_b_dly = v.b_dly; cfg_r_dly = v.r_dly; cfg_resp = v.resp;
    clear_stats();
    send_cmd(v.we, v.addr, v.wdata, v.wstrb);
    wait_rsp(rc);
    take_rsp(v.hold, rd, rs);
    chk({tag, "_rdata"}, 64'(rd), 64'(v.exp_rdata));
    chk({tag, "_resp"}, 64'(rs), 64'(v.exp_resp));
    chk({tag, "_rsp_latency"}, 64'(rc), 64'(hs_cyc));
    if (v.we) begin
      chk({tag, "_aw_count"}, 64'(n_aw), 1);
      chk({tag, "_w_count"}, 64'(n_w), 1);
      chk({tag, "_b_count"}, 64'(n_b), 1);
      chk({tag, "_ar_count"}, 64'(n_ar), 0);
      chk({tag, "_awaddr"}, 64'(seen_awaddr), 64'(v.addr));
      chk({tag, "_aw_w_skew"}, 64'(aw_cyc - w_cyc), 64'(v.aw_dly - v.w_dly));
      model_write(v.addr, v.wdata, v.wstrb);
    end else begin
      chk({tag, "_ar_count"}, 64'(n_ar), 1);
      chk({tag, "_r_count"}, 64'(n_r), 1);
      chk({tag, "_aw_count"}, 64'(n_aw), 0);
      chk({tag, "_araddr"}, 64'(seen_araddr), 64'(v.addr));
      chk({tag, "_rready_gap"}, 64'(rready_gap), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [10];
    vec_t v;
    logic [W-1:0] rd;
    logic [1:0]   rs;
    int rc;
    bit saw_rsp;

    tbl[0] = mk(1, 'h10, 'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'd0, 0, 'h0,        2'd0);
    tbl[1] = mk(0, 'h10, 'h0,        4'h0, 0, 0, 0, 0, 0, 2'd0, 0, 'hDEADBEEF, 2'd0);
    tbl[2] = mk(1, 'h10, 'h11223344, 4'h5, 3, 0, 0, 1, 0, 2'd0, 1, 'h0,        2'd0);
    tbl[3] = mk(0, 'h10, 'h0,        4'h0, 0, 0, 2, 0, 2, 2'd0, 0, 'hDE22BE44, 2'd0);
    tbl[4] = mk(1, 'h24, 'h12345678, 4'hF, 0, 2, 0, 0, 0, 2'd0, 0, 'h0,        2'd0);
    tbl[5] = mk(0, 'h24, 'h0,        4'h0, 0, 0, 0, 0, 5, 2'd0, 0, 'h12345678, 2'd0);
    tbl[6] = mk(0, 'h40, 'h0,        4'h0, 0, 0, 0, 0, 1, 2'd2, 0, 'h0,        2'd2);
    tbl[7] = mk(1, 'h44, 'hAABBCCDD, 4'hF, 1, 1, 0, 2, 0, 2'd3, 0, 'h0,        2'd3);
    tbl[8] = mk(1, 'h13, 'hCAFEF00D, 4'h8, 0, 0, 0, 0, 0, 2'd1, 2, 'h0,        2'd1);
    tbl[9] = mk(0, 'h13, 'h0,        4'h0, 0, 0, 1, 0, 0, 2'd0, 3, 'hCA000000, 2'd0);

    ARESET = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_ar_dly = 0; cfg_b_dly = 0; cfg_r_dly = 0; cfg_resp = 0;
    clear_stats();
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_ctrl", 64'({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}), 0);
    chk("rst_addr", {M_AWADDR, M_ARADDR}, 0);
    chk("rst_wdata_resp", 64'({M_WDATA, M_WSTRB, rsp_resp}), 0);
    chk("rst_rdata", 64'(rsp_rdata), 0);
    ARESET = 0;
    chk("rst_release_cmd_ready", 64'(cmd_ready), 1);
    @(posedge ACLK);
    #1;
    chk("cmd_ready_first_edge", 64'(cmd_ready), 1);

    for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Response back-pressure with the next command already waiting.
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_ar_dly = 0; cfg_b_dly = 0; cfg_r_dly = 0; cfg_resp = 0;
    clear_stats();
    send_cmd(0, 'h24, 'h0, 4'h0);
    wait_rsp(rc);
    cmd_we = 1; cmd_addr = 'h28; cmd_wdata = 'h0BADCAFE; cmd_wstrb = 4'hF; cmd_valid = 1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_cmd_ready", 64'(cmd_ready), 0);
      chk("bp_rsp_valid", 64'(rsp_valid), 1);
      chk("bp_rsp_rdata", 64'(rsp_rdata), 'h12345678);
      @(posedge ACLK);
      #1;
    end
    rsp_ready = 1;
    chk("bp_hs_cycle_cmd_ready", 64'(cmd_ready), 0);
    @(posedge ACLK);
    #1;
    rsp_ready = 0;
    chk("bp_after_hs_cmd_ready", 64'(cmd_ready), 1);
    chk("bp_after_hs_rsp_valid", 64'(rsp_valid), 0);
    @(posedge ACLK);
    #1;
    cmd_valid = 0;
    chk("wr_awvalid_n1", 64'(M_AWVALID), 1);
    chk("wr_wvalid_n1", 64'(M_WVALID), 1);
    chk("wr_awaddr_n1", 64'(M_AWADDR), 'h28);
    wait_rsp(rc);
    take_rsp(0, rd, rs);
    chk("bp_wr_resp", 64'(rs), 0);
    model_write('h28, 'h0BADCAFE, 4'hF);

    // Reset while the read is waiting for data.
    cfg_r_dly = 20;
    clear_stats();
    send_cmd(0, 'h30, 'h0, 4'h0);
    chk("rd_arvalid_n1", 64'(M_ARVALID), 1);
    chk("rd_araddr_n1", 64'(M_ARADDR), 'h30);
    repeat (3) begin
      @(posedge ACLK);
      #1;
    end
    chk("rd_data_rready", 64'(M_RREADY), 1);
    ARESET = 1;
    #1;
    chk("midrst_ctrl", 64'({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}), 0);
    chk("midrst_araddr", 64'(M_ARADDR), 0);
    chk("midrst_rdata", 64'(rsp_rdata), 0);
    chk("midrst_awaddr_wdata", {M_AWADDR, M_WDATA}, 0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 0;
    chk("midrst_release_cmd_ready", 64'(cmd_ready), 1);
    saw_rsp = 0;
    repeat (25) begin
      @(posedge ACLK);
      #1;
      if (rsp_valid) saw_rsp = 1;
    end
    chk("midrst_no_rsp", 64'(saw_rsp), 0);
    cfg_r_dly = 0;

    // Random traffic against the reference memory model.
    for (int i = 0; i < 40; i++) begin
      v.we     = 1'($urandom_range(0, 1));
      v.addr   = W'(4 * $urandom_range(0, 3));
      v.wdata  = $urandom;
      v.wstrb  = SW'($urandom_range(0, 15));
      v.aw_dly = $urandom_range(0, 3);
      v.w_dly  = $urandom_range(0, 3);
      v.ar_dly = $urandom_range(0, 3);
      v.b_dly  = $urandom_range(0, 3);
      v.r_dly  = $urandom_range(0, 4);
      v.resp   = 2'($urandom_range(0, 3));
      v.hold   = $urandom_range(0, 2);
      v.exp_rdata = v.we ? '0 : (model_mem.exists(v.addr) ? model_mem[v.addr] : '0);
      v.exp_resp  = v.resp;
      run_txn(v, $sformatf("rnd%0d", i));
    end

    chk("valid_payload_stability", 64'(stab_err), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
